// File: rtl/ir_pkg.sv
// Shared constants, FSM state encoding and output rounding for the IR convolver.
package ir_pkg;

  localparam int TAPS  = 256;
  localparam int W     = 16;
  localparam int ACC_W = 2 * W + $clog2(TAPS);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MAC   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Round half-up at bit W-2, drop W-1 fraction bits, clamp to signed W bits.
  // The accumulator is passed sign-extended to 64 bits so any TAPS fits.
  function automatic logic [W-1:0] round_sat(input logic signed [63:0] acc_v);
    logic signed [63:0] rnd_v;
    logic signed [63:0] shf_v;
    logic signed [63:0] hi_v;
    logic signed [63:0] lo_v;
    logic [W-1:0]       res_v;
    hi_v  = (64'sd1 <<< (W - 1)) - 64'sd1;
    lo_v  = -(64'sd1 <<< (W - 1));
    rnd_v = acc_v + (64'sd1 <<< (W - 2));
    shf_v = rnd_v >>> (W - 1);
    if (shf_v > hi_v) begin
      res_v = hi_v[W-1:0];
    end else if (shf_v < lo_v) begin
      res_v = lo_v[W-1:0];
    end else begin
      res_v = shf_v[W-1:0];
    end
    return res_v;
  endfunction

endpackage

// File: rtl/ir_convolver_history.sv
// Sample history storage: single-port RAM, synchronous write, combinational read.
// Contents carry no reset; the convolver zeroes them in its CLEAR state.
module ir_history_ram #(
  parameter int DEPTH = ir_pkg::TAPS,
  parameter int DW    = ir_pkg::W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata
);
  import ir_pkg::*;

  logic [DW-1:0] mem_r [DEPTH];

  // Write port: one entry per edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  assign rdata = mem_r[addr];

endmodule

// File: rtl/ir_convolver.sv
// Sequential FIR: one multiply-accumulate per cycle over a TAPS-deep sample ring.
// TAPS must be a power of two and W must match ir_pkg::W (shared rounding helper).
module ir_convolver #(
  parameter int TAPS = ir_pkg::TAPS,
  parameter int W    = ir_pkg::W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [TAPS-1:0][W-1:0] weights,
  input  logic [W-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [W-1:0]           out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);
  import ir_pkg::*;

  localparam int AW       = $clog2(TAPS);
  localparam int ACC_BITS = 2 * W + AW;
  localparam logic [AW-1:0] K_LAST = AW'(TAPS - 1);
  localparam logic [AW-1:0] K_ONE  = AW'(1);

  state_e                      state_r;
  logic [AW-1:0]               wp_r;
  logic [AW-1:0]               k_r;
  logic signed [ACC_BITS-1:0]  acc_r;
  logic [W-1:0]                out_data_r;
  logic                        out_valid_r;
  logic                        in_ready_r;
  logic                        busy_r;

  logic                        accept_s;
  logic                        ram_we_s;
  logic [AW-1:0]               ram_addr_s;
  logic [W-1:0]                ram_wdata_s;
  logic [W-1:0]                ram_rdata_s;
  logic signed [2*W-1:0]       prod_s;
  logic signed [ACC_BITS-1:0]  acc_next_s;
  logic signed [63:0]          acc_ext_s;

  assign accept_s = in_valid & in_ready_r;

  ir_history_ram #(
    .DEPTH (TAPS),
    .DW    (W)
  ) u_hist (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // RAM port steering: zero slot k in CLEAR, newest slot on accept, tap (wp-k) in MAC
  always_comb begin
    ram_we_s    = 1'b0;
    ram_addr_s  = wp_r;
    ram_wdata_s = {W{1'b0}};
    case (state_r)
      ST_CLEAR: begin
        ram_we_s    = 1'b1;
        ram_addr_s  = k_r;
        ram_wdata_s = {W{1'b0}};
      end
      ST_IDLE: begin
        ram_we_s    = accept_s;
        ram_addr_s  = wp_r;
        ram_wdata_s = in_data;
      end
      ST_MAC: begin
        ram_we_s    = 1'b0;
        ram_addr_s  = wp_r - k_r;
        ram_wdata_s = {W{1'b0}};
      end
      ST_OUT: begin
        ram_we_s    = 1'b0;
        ram_addr_s  = wp_r;
        ram_wdata_s = {W{1'b0}};
      end
      default: begin
        ram_we_s    = 1'b0;
        ram_addr_s  = wp_r;
        ram_wdata_s = {W{1'b0}};
      end
    endcase
  end

  // MAC datapath: product of current tap, sign-extended accumulation and rounding input
  always_comb begin
    prod_s     = $signed(ram_rdata_s) * $signed(weights[k_r]);
    acc_next_s = acc_r + {{AW{prod_s[2*W-1]}}, prod_s};
    acc_ext_s  = {{(64 - ACC_BITS){acc_next_s[ACC_BITS-1]}}, acc_next_s};
  end

  // Control FSM with all handshake and status outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_CLEAR;
      wp_r        <= {AW{1'b0}};
      k_r         <= {AW{1'b0}};
      acc_r       <= {ACC_BITS{1'b0}};
      out_data_r  <= {W{1'b0}};
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (k_r == K_LAST) begin
            k_r        <= {AW{1'b0}};
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            k_r <= k_r + K_ONE;
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            acc_r      <= {ACC_BITS{1'b0}};
            k_r        <= {AW{1'b0}};
            state_r    <= ST_MAC;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end
        ST_MAC: begin
          acc_r <= acc_next_s;
          k_r   <= k_r + K_ONE;
          if (k_r == K_LAST) begin
            out_data_r  <= round_sat(acc_ext_s);
            out_valid_r <= 1'b1;
            wp_r        <= wp_r + K_ONE;
            state_r     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_CLEAR;
          k_r         <= {AW{1'b0}};
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b0;
          busy_r      <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_ir_convolver.sv
// Bench for ir_convolver: FIR reference model over a queue of accepted samples,
// per-cycle output compare, directed impulse/saturation/backpressure/reset cases
// and a randomized run long enough to wrap the history ring.
module tb_ir_convolver;

  localparam int TAPS = 256;
  localparam int W    = 16;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [TAPS-1:0][W-1:0] weights;
  logic [W-1:0]           in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  int       n_vec = 0;
  int       n_err = 0;
  longint   cyc = 0;
  int       mdl_hist[$];
  longint   exp_q[$];
  longint   acc_edge = 0;
  logic     ov_prev = 1'b0;
  logic [W-1:0] last_out = '0;

  ir_convolver #(.TAPS(TAPS), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .weights   (weights),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Round half up to Q1.15 by floor division, then clamp
  function automatic longint ref_round(input longint s);
    longint v, q, half, unit, hi, lo;
    unit = longint'(1) << (W - 1);
    half = longint'(1) << (W - 2);
    hi   = unit - 1;
    lo   = -unit;
    v = s + half;
    if (v >= 0) q = v / unit;
    else        q = -((-v + unit - 1) / unit);
    if (q > hi) q = hi;
    else if (q < lo) q = lo;
    return q;
  endfunction

  // Direct FIR: newest accepted sample times weights[0], older ones by age
  function automatic longint model_out();
    longint s = 0;
    for (int n = 0; n < mdl_hist.size(); n++)
      s += longint'(mdl_hist[n]) * longint'($signed(weights[n]));
    return ref_round(s);
  endfunction

  // Compare process: reset values, output data every valid cycle, latency, in_ready rules
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_hist.delete();
      exp_q.delete();
      ov_prev = 1'b0;
      chk("rst_out_valid", longint'(out_valid), 0);
      chk("rst_in_ready", longint'(in_ready), 0);
      chk("rst_busy", longint'(busy), 1);
      chk("rst_out_data", longint'(out_data), 0);
    end else begin
      chk("busy_vs_ready", longint'(busy), longint'(!in_ready));
      if (out_valid) begin
        chk("out_pending", longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) chk("out_data", longint'($signed(out_data)), exp_q[0]);
        chk("in_ready_in_out", longint'(in_ready), 0);
        if (!ov_prev) begin
          chk("latency", cyc - acc_edge, TAPS);
          last_out = out_data;
        end
        if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (in_valid && in_ready) begin
        mdl_hist.push_front(int'($signed(in_data)));
        if (mdl_hist.size() > TAPS) void'(mdl_hist.pop_back());
        exp_q.push_back(model_out());
        acc_edge = cyc + 1;
      end
      ov_prev = out_valid;
    end
  end

  task automatic check_clear();
    int n = 0;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("clear_cycles", n, TAPS);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_clear();
  endtask

  task automatic send(input logic [W-1:0] s, output int waited);
    int n = 0;
    in_data  = s;
    in_valid = 1'b1;
    while (!in_ready && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", longint'(in_ready), 1);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    waited = n;
  endtask

  task automatic wait_out(input int hold, input bit pulse);
    int n = 0;
    while (!out_valid && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) begin
      chk("out_timeout", longint'(out_valid), 1);
    end else begin
      for (int i = 0; i < hold; i++) begin
        if (pulse) begin
          in_valid = ~in_valid;
          in_data  = W'($urandom);
        end
        @(posedge clk); #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic set_all_weights(input logic [W-1:0] v);
    for (int k = 0; k < TAPS; k++) weights[k] = v;
  endtask

  initial begin
    int w;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    weights   = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_clear();

    // Pin the reference rounding against hand-computed values
    chk("pin_impulse", ref_round(longint'(32767) * 1305), 1305);
    chk("pin_neg_half", ref_round(longint'(-32768) * 32767), -32767);
    chk("pin_neg_sat", ref_round(longint'(-65536) * 32767), -32768);
    chk("pin_pos_sat", ref_round(longint'(256) * 32767 * 32767), 32767);

    // Impulse weights; tap 255 non-zero exposes stale history after reset
    weights      = '0;
    weights[0]   = 16'h0519;
    weights[1]   = 16'h0100;
    weights[2]   = 16'hFE00;
    weights[255] = 16'h4000;

    send(16'h7FFF, w);
    wait_out(0, 1'b0);
    chk("first_impulse", longint'(last_out), longint'(16'h0519));

    // Reset at MAC tap 100: result discarded, history rezeroed
    send(16'h7FFF, w);
    repeat (100) @(posedge clk);
    #1;
    do_reset();
    send(16'h7FFF, w);
    wait_out(0, 1'b0);
    chk("post_reset_impulse", longint'(last_out), longint'(16'h0519));
    send(16'h0000, w);
    wait_out(0, 1'b0);
    chk("impulse_tap1", longint'(last_out), longint'(16'h0100));
    send(16'h0000, w);
    wait_out(0, 1'b0);
    chk("impulse_tap2", longint'(last_out), longint'(16'hFE00));

    // Backpressure: hold out_ready low 10 cycles while in_valid toggles
    send(16'h1234, w);
    wait_out(10, 1'b1);
    chk("bp_ready_after", longint'(in_ready), 1);
    send(16'h0000, w);
    chk("bp_accept_next", w, 0);
    wait_out(0, 1'b0);

    // Saturation from a clean history
    do_reset();
    set_all_weights(16'h8000);
    send(16'h7FFF, w);
    wait_out(0, 1'b0);
    chk("sat_neg_first", longint'(last_out), longint'(16'h8001));
    send(16'h7FFF, w);
    wait_out(0, 1'b0);
    chk("sat_neg_second", longint'(last_out), longint'(16'h8000));
    set_all_weights(16'h7FFF);
    send(16'h7FFF, w);
    wait_out(0, 1'b0);
    chk("sat_pos", longint'(last_out), longint'(16'h7FFF));

    // Random weights and samples, enough to wrap the write pointer
    for (int k = 0; k < TAPS; k++) weights[k] = W'($urandom);
    for (int i = 0; i < 262; i++) begin
      send(W'($urandom), w);
      wait_out(int'($urandom_range(0, 2)), 1'b0);
    end

    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", longint'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
